wb_write_port: RTL and testbench
================================

// Module: wb_write_port
// PURPOSE
//  Write-back stage and sole driver of the register-file write port (regwrite/rd/writedata).
//  Holds the MEM/WB pipeline register and selects ALU result vs load data.
//  Merges a second, long-latency result source (multiply/divide unit) through a small
//  queue, since the register file has one write port. Also exports the write in flight
//  for forwarding and hazard logic.
// PARAMETERS
//  QDEPTH  2   entries in the long-latency result queue (power of 2, >=2)
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous active-high reset
//  stall          in   1   upstream stalled: MEM/WB captures a bubble this edge
//  flush          in   1   squash: MEM/WB captures a bubble this edge (wins over all)
//  mem_valid      in   1   MEM stage holds a real instruction
//  mem_regwrite   in   1   instruction writes a register
//  mem_memtoreg   in   1   1 = write mem_readdata, 0 = write mem_aluresult
//  mem_rd         in   5   destination register
//  mem_aluresult  in   32  ALU result
//  mem_readdata   in   32  data-memory load result
//  lat_valid      in   1   long-latency result offered
//  lat_rd         in   5   its destination register
//  lat_data       in   32  its result
//  lat_ready      out  1   queue can accept (= !full)
//  lat_pending    out  1   queue non-empty (hazard unit stalls readers of queued rd)
//  regwrite       out  1   register-file write enable
//  rd             out  5   register-file write address
//  writedata      out  32  register-file write data
// BEHAVIOUR
//  Reset (async, immediate): MEM/WB valid=0, all WB fields 0, queue empty.
//   Outputs during/after reset: regwrite=0, rd=0, writedata=0, lat_ready=1, lat_pending=0.
//  MEM/WB register, each posedge:
//   - flush=1 or stall=1 -> load bubble (wb_valid=0). flush overrides stall.
//   - else capture mem_* with wb_valid=mem_valid; the data mux is applied at capture
//     (wb_data = memtoreg ? readdata : aluresult).
//   - Each pipeline instruction drives the write port exactly once, in the cycle
//     after capture; the register file commits it on the following edge.
//  Pipeline write is live when wb_valid & wb_regwrite & wb_rd!=0.
//  Write-port arbitration (combinational from state):
//   - pipeline write live -> regwrite=1, rd=wb_rd, writedata=wb_data.
//   - else queue non-empty -> drive queue head; pop on this edge.
//   - else regwrite=0, rd=0, writedata=0 (no X, no stale values).
//   - The pipeline always wins. The queue drains only in pipeline idle/bubble cycles.
//  Queue: FIFO, QDEPTH entries, circular rd/wr pointers wrapping at QDEPTH,
//   count 0..QDEPTH.
//   - push when lat_valid & lat_ready. lat_ready is low when full; lat_valid while
//     full is ignored, and the source must hold it.
//   - lat_rd==0: handshake completes but nothing is enqueued (r0 stays 0).
//   - push and pop in the same cycle: count unchanged, head advances, data order kept.
//   - pop from empty never occurs.
//  Register 0 is never written by either source.
//  Reset mid-operation: queued results are lost and the WB instruction is dropped;
//   the write port deasserts immediately.
// TESTING
//  1 ALU op rd=5, alures=0x1234 -> one cycle later: regwrite=1, rd=5, writedata=0x1234,
//    for exactly 1 cycle.
//  2 Load rd=7, memtoreg=1, readdata=0xDEADBEEF, alures=0x40 -> writedata=0xDEADBEEF.
//  3 Instruction with rd=0, and a lat push with rd=0 -> regwrite never asserted;
//    lat_pending stays 0.
//  4 Back-to-back pipeline writes plus 3 lat pushes -> lat_ready=0 after 2 pushes;
//    a bubble (stall=1) drains the head.
//  5 lat push and pop in the same cycle with count=1 -> count stays 1; FIFO order verified.
//  6 Assert rst while the queue holds 2 entries and wb_valid=1 -> outputs 0 at once,
//    lat_ready=1, no writes after release.

Source files
------------

// File: rtl/wb_write_port.sv
// wb_write_port: MEM/WB register plus register-file write port shared with a queued long-latency result source
module wb_write_port #(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_regwrite,
   input  logic        mem_memtoreg,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_aluresult,
   input  logic [31:0] mem_readdata,
   input  logic        lat_valid,
   input  logic [4:0]  lat_rd,
   input  logic [31:0] lat_data,
   output logic        lat_ready,
   output logic        lat_pending,
   output logic        regwrite,
   output logic [4:0]  rd,
   output logic [31:0] writedata
);
   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] q_full = (AW+1)'(QDEPTH);
   logic          wb_valid;
   logic          wb_regwrite;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic [4:0]    q_rd [QDEPTH];
   logic [31:0]   q_data [QDEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [AW:0]   count;
   logic          wb_live;
   logic          push;
   logic          pop;
   always_comb begin
      wb_live     = wb_valid && wb_regwrite && (wb_rd != 5'd0);
      lat_ready   = count != q_full;
      lat_pending = count != '0;
      pop         = !wb_live && lat_pending;
      push        = lat_valid && lat_ready && (lat_rd != 5'd0);
      regwrite    = wb_live || pop;
      rd          = wb_live ? wb_rd : pop ? q_rd[rptr] : 5'd0;
      writedata   = wb_live ? wb_data : pop ? q_data[rptr] : 32'd0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_rd       <= 5'd0;
         wb_data     <= 32'd0;
         rptr        <= '0;
         wptr        <= '0;
         count       <= '0;
      end else begin
         if (flush || stall) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
         end else begin
            wb_valid    <= mem_valid;
            wb_regwrite <= mem_regwrite;
            wb_rd       <= mem_rd;
            wb_data     <= mem_memtoreg ? mem_readdata : mem_aluresult;
         end
         rptr  <= rptr + AW'(pop);
         wptr  <= wptr + AW'(push);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // storage needs no reset: entries are only read while count says they are valid
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wptr]   <= lat_rd;
         q_data[wptr] <= lat_data;
      end
   end
endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port: vector table for the pipeline path, scoreboard queue for long-latency results
module tb_wb_write_port;
   localparam int QDEPTH = 2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, mem_valid = 1'b0, mem_regwrite = 1'b0, mem_memtoreg = 1'b0;
   logic [4:0]  mem_rd = 5'd0;
   logic [31:0] mem_aluresult = 32'd0, mem_readdata = 32'd0;
   logic        lat_valid = 1'b0;
   logic [4:0]  lat_rd = 5'd0;
   logic [31:0] lat_data = 32'd0;
   logic        lat_ready, lat_pending, regwrite;
   logic [4:0]  rd;
   logic [31:0] writedata;

   wb_write_port #(.QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
      .mem_aluresult(mem_aluresult), .mem_readdata(mem_readdata), .lat_valid(lat_valid),
      .lat_rd(lat_rd), .lat_data(lat_data), .lat_ready(lat_ready), .lat_pending(lat_pending),
      .regwrite(regwrite), .rd(rd), .writedata(writedata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st, fl, mv, mw, mm;
      logic [4:0]  mrd;
      logic [31:0] alu, rdt;
      logic        ewe;
      logic [4:0]  erd;
      logic [31:0] ewd;
   } vec_t;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   vec_t vecs[11];
   ent_t lat_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   pend_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: drive at negedge, check handshake before the edge, check write port after it
   task automatic step(input logic st, input logic fl, input logic mv, input logic mw, input logic mm,
                       input logic [4:0] mrd, input logic [31:0] alu, input logic [31:0] rdt,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ewd);
      int  occ;
      bit  acc;
      @(negedge clk);
      stall = st; flush = fl; mem_valid = mv; mem_regwrite = mw; mem_memtoreg = mm;
      mem_rd = mrd; mem_aluresult = alu; mem_readdata = rdt;
      lat_valid = lv; lat_rd = lrd; lat_data = ld;
      #1;
      occ = lat_q.size() + int'(pend_pop);
      chk("lat_ready", 32'(lat_ready), 32'(occ < QDEPTH));
      chk("lat_pending", 32'(lat_pending), 32'(occ != 0));
      acc = lv && (occ < QDEPTH);
      @(posedge clk);
      #1;
      pend_pop = 0;
      if (acc && lrd != 5'd0) lat_q.push_back('{rd: lrd, d: ld});
      if (!ewe && lat_q.size() != 0) begin
         ewe = 1'b1;
         erd = lat_q[0].rd;
         ewd = lat_q[0].d;
         void'(lat_q.pop_front());
         pend_pop = 1;
      end
      chk("regwrite", 32'(regwrite), 32'(ewe));
      chk("rd", 32'(rd), 32'(erd));
      chk("writedata", writedata, ewd);
   endtask

   task automatic idle();
      step(0,0,0,0,0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{0,0,1,1,0, 5'd5,  32'h1234,     32'h0,        1, 5'd5,  32'h1234};
      vecs[1]  = '{0,0,0,0,0, 5'd0,  32'h0,        32'h0,        0, 5'd0,  32'h0};
      vecs[2]  = '{0,0,1,1,1, 5'd7,  32'h40,       32'hDEADBEEF, 1, 5'd7,  32'hDEADBEEF};
      vecs[3]  = '{0,0,1,1,0, 5'd0,  32'h55,       32'h0,        0, 5'd0,  32'h0};
      vecs[4]  = '{0,0,1,0,0, 5'd9,  32'h99,       32'h0,        0, 5'd0,  32'h0};
      vecs[5]  = '{1,0,1,1,0, 5'd3,  32'h33,       32'h0,        0, 5'd0,  32'h0};
      vecs[6]  = '{0,1,1,1,0, 5'd3,  32'h33,       32'h0,        0, 5'd0,  32'h0};
      vecs[7]  = '{1,1,1,1,1, 5'd4,  32'h44,       32'h4444,     0, 5'd0,  32'h0};
      vecs[8]  = '{0,0,1,1,0, 5'd31, 32'hFFFFFFFF, 32'h0,        1, 5'd31, 32'hFFFFFFFF};
      vecs[9]  = '{0,0,0,1,0, 5'd4,  32'h4,        32'h0,        0, 5'd0,  32'h0};
      vecs[10] = '{0,0,1,1,0, 5'd12, 32'hCAFE,     32'hBAD,      1, 5'd12, 32'hCAFE};

      #2;
      chk("reset regwrite", 32'(regwrite), 32'd0);
      chk("reset rd", 32'(rd), 32'd0);
      chk("reset writedata", writedata, 32'd0);
      chk("reset lat_ready", 32'(lat_ready), 32'd1);
      chk("reset lat_pending", 32'(lat_pending), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         step(vecs[i].st, vecs[i].fl, vecs[i].mv, vecs[i].mw, vecs[i].mm, vecs[i].mrd,
              vecs[i].alu, vecs[i].rdt, 0, 5'd0, 32'd0, vecs[i].ewe, vecs[i].erd, vecs[i].ewd);

      // lat push to r0 completes the handshake but never enqueues
      step(0,0,0,0,0, 5'd0, 32'd0, 32'd0, 1, 5'd0, 32'hBEEF, 0, 5'd0, 32'd0);
      idle();

      // pipeline busy every cycle while three results are offered; third waits for a bubble
      step(0,0,1,1,0, 5'd1, 32'h101, 32'd0, 1, 5'd10, 32'hA0, 1, 5'd1, 32'h101);
      step(0,0,1,1,0, 5'd2, 32'h102, 32'd0, 1, 5'd11, 32'hA1, 1, 5'd2, 32'h102);
      step(0,0,1,1,0, 5'd3, 32'h103, 32'd0, 1, 5'd12, 32'hA2, 1, 5'd3, 32'h103);
      step(1,0,1,1,0, 5'd4, 32'h104, 32'd0, 1, 5'd12, 32'hA2, 0, 5'd0, 32'd0);
      step(0,0,0,0,0, 5'd0, 32'd0,   32'd0, 1, 5'd12, 32'hA2, 0, 5'd0, 32'd0);
      // count=1 with a pop in progress: push and pop share this edge
      step(0,0,0,0,0, 5'd0, 32'd0,   32'd0, 1, 5'd12, 32'hA2, 0, 5'd0, 32'd0);
      idle();
      idle();

      // fill the queue behind live pipeline writes, then reset with WB valid
      step(0,0,1,1,0, 5'd20, 32'h200, 32'd0, 1, 5'd21, 32'hB1, 1, 5'd20, 32'h200);
      step(0,0,1,1,0, 5'd22, 32'h202, 32'd0, 1, 5'd23, 32'hB3, 1, 5'd22, 32'h202);
      step(0,0,1,1,0, 5'd24, 32'h204, 32'd0, 0, 5'd0,  32'd0, 1, 5'd24, 32'h204);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst regwrite", 32'(regwrite), 32'd0);
      chk("midrst rd", 32'(rd), 32'd0);
      chk("midrst writedata", writedata, 32'd0);
      chk("midrst lat_ready", 32'(lat_ready), 32'd1);
      chk("midrst lat_pending", 32'(lat_pending), 32'd0);
      lat_q.delete();
      pend_pop = 0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle();
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
